// File: rtl/load_store_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// load_store_unit : RISC-V load/store initiator for a 64-bit word memory
// Rev 1.0
// ----------------------------------------------------------------------------
module load_store_unit #(
  parameter int ADDRSIZE = 64,
  parameter int WORDSIZE = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [2:0]          req_funct3,
  input  logic [ADDRSIZE-1:0] req_addr,
  input  logic [WORDSIZE-1:0] req_wdata,
  output logic                resp_valid,
  output logic [WORDSIZE-1:0] resp_rdata,
  output logic                resp_err,
  output logic                mem_wren,
  output logic                mem_rden,
  output logic [ADDRSIZE-1:0] mem_addr,
  output logic [WORDSIZE-1:0] mem_d,
  input  logic [WORDSIZE-1:0] mem_q
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t r_state, w_next;

  logic                r_we;
  logic [2:0]          r_funct3;
  logic [ADDRSIZE-1:0] r_addr;
  logic [WORDSIZE-1:0] r_wdata;
  logic [WORDSIZE-1:0] r_memd;
  logic [WORDSIZE-1:0] r_rdata;
  logic                r_err;

  logic                w_accept, w_illegal, w_misal, w_req_err, w_req_sd;
  logic [2:0]          w_off;
  logic [WORDSIZE-1:0] w_lane, w_load, w_wsh, w_mask, w_merged;
  logic [7:0]          w_bmask;
  logic                w_sx;

  // Request decode at the acceptance edge
  always_comb begin
    w_off     = req_addr[2:0];
    w_accept  = (r_state == IDLE) && req_valid;
    w_illegal = req_we ? req_funct3[2] : (req_funct3 == 3'b111);
    w_misal   = 1'b0;
    case (req_funct3[1:0])
      2'b01:   w_misal = w_off[0];
      2'b10:   w_misal = (w_off[1:0] != 2'b00);
      2'b11:   w_misal = (w_off != 3'b000);
      default: w_misal = 1'b0;
    endcase
    w_req_err = w_illegal | w_misal;
    w_req_sd  = req_we && (req_funct3[1:0] == 2'b11);
  end

  // Load extraction and store merge, both working on the live mem_q
  always_comb begin
    w_lane = mem_q >> {r_addr[2:0], 3'b000};
    w_load = mem_q;
    case (r_funct3[1:0])
      2'b00: begin
        w_sx   = ~r_funct3[2] & w_lane[7];
        w_load = {{56{w_sx}}, w_lane[7:0]};
      end
      2'b01: begin
        w_sx   = ~r_funct3[2] & w_lane[15];
        w_load = {{48{w_sx}}, w_lane[15:0]};
      end
      2'b10: begin
        w_sx   = ~r_funct3[2] & w_lane[31];
        w_load = {{32{w_sx}}, w_lane[31:0]};
      end
      default: begin
        w_sx   = 1'b0;
        w_load = mem_q;
      end
    endcase

    case (r_funct3[1:0])
      2'b00:   w_bmask = 8'h01 << r_addr[2:0];
      2'b01:   w_bmask = 8'h03 << r_addr[2:0];
      2'b10:   w_bmask = 8'h0F << r_addr[2:0];
      default: w_bmask = 8'hFF;
    endcase
    w_mask = '0;
    for (int i = 0; i < 8; i++) begin
      w_mask[i*8 +: 8] = {8{w_bmask[i]}};
    end
    w_wsh    = r_wdata << {r_addr[2:0], 3'b000};
    w_merged = (mem_q & ~w_mask) | (w_wsh & w_mask);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (w_req_err)     w_next = RESP;
          else if (w_req_sd) w_next = WRITE;
          else               w_next = READ;
        end
      end
      READ:    w_next = r_we ? WRITE : RESP;
      WRITE:   w_next = RESP;
      default: w_next = IDLE;
    endcase
  end

  // Response fields only change on the edge that enters RESP
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we     <= 1'b0;
      r_funct3 <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_memd   <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            if (w_req_err) begin
              r_err   <= 1'b1;
              r_rdata <= '0;
            end else if (w_req_sd) begin
              r_memd  <= req_wdata;
            end
          end
        end
        READ: begin
          if (r_we) begin
            r_memd <= w_merged;
          end else begin
            r_rdata <= w_load;
            r_err   <= 1'b0;
          end
        end
        WRITE: begin
          r_rdata <= '0;
          r_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (r_state == IDLE);
  assign resp_valid = (r_state == RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
  assign mem_rden   = (r_state == READ);
  assign mem_wren   = (r_state == WRITE);
  assign mem_addr   = {3'b000, r_addr[ADDRSIZE-1:3]};
  assign mem_d      = r_memd;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_load_store_unit : directed self-checking bench for load_store_unit
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        mem_wren;
  logic        mem_rden;
  logic [63:0] mem_addr;
  logic [63:0] mem_d;
  logic [63:0] mem_q;

  logic [63:0] mem [0:7];

  int n_checks = 0;
  int n_pass   = 0;

  load_store_unit #(.ADDRSIZE(64), .WORDSIZE(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_wren(mem_wren), .mem_rden(mem_rden), .mem_addr(mem_addr),
    .mem_d(mem_d), .mem_q(mem_q)
  );

  always #5 clk = ~clk;

  assign mem_q = mem_rden ? mem[mem_addr[2:0]] : 64'h0;

  always @(posedge clk) begin
    if (mem_wren) mem[mem_addr[2:0]] <= mem_d;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // One request: accept, then watch every cycle up to the response
  task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                      input logic [63:0] addr, input logic [63:0] wdata,
                      input int exp_lat, input logic [63:0] exp_rdata, input logic exp_err,
                      input int exp_rd, input int exp_wr,
                      input logic [63:0] exp_maddr, input logic [63:0] exp_d);
    int n, rd, wr, lat;
    logic both, done, err;
    logic [63:0] rdata, seen_addr, seen_d;
    @(negedge clk);
    check({tag, ".ready"}, {63'b0, req_ready}, 64'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    // garbage on req_* while busy must be ignored
    req_valid = 1'b0; req_we = ~we; req_funct3 = 3'b111; req_addr = 64'hFFF; req_wdata = '1;
    n = 1; rd = 0; wr = 0; both = 1'b0; done = 1'b0; lat = -1;
    err = 1'b0; rdata = '0; seen_addr = '0; seen_d = '0;
    while (!done && n <= 8) begin
      if (mem_rden) begin rd++; seen_addr = mem_addr; end
      if (mem_wren) begin wr++; seen_addr = mem_addr; seen_d = mem_d; end
      if (mem_rden && mem_wren) both = 1'b1;
      if (resp_valid) begin
        done = 1'b1; lat = n; rdata = resp_rdata; err = resp_err;
      end else begin
        @(negedge clk);
        n++;
      end
    end
    check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    check({tag, ".rdata"}, rdata, exp_rdata);
    check({tag, ".err"}, {63'b0, err}, {63'b0, exp_err});
    check({tag, ".rden_cycles"}, 64'(rd), 64'(exp_rd));
    check({tag, ".wren_cycles"}, 64'(wr), 64'(exp_wr));
    check({tag, ".rd_wr_overlap"}, {63'b0, both}, 64'd0);
    if (exp_rd + exp_wr > 0) check({tag, ".mem_addr"}, seen_addr, exp_maddr);
    if (exp_wr > 0) check({tag, ".mem_d"}, seen_d, exp_d);
    @(negedge clk);
    check({tag, ".pulse_one_cycle"}, {63'b0, resp_valid}, 64'd0);
    check({tag, ".hold_rdata"}, resp_rdata, exp_rdata);
  endtask

  initial begin
    logic [63:0] got [0:1];
    int ng;
    for (int i = 0; i < 8; i++) mem[i] = 64'h1111_0000_0000_0000 * 64'(i);
    mem[1] = 64'h0123_4567_89AB_CDEF;

    // Reset state
    #12;
    check("rst.resp_valid", {63'b0, resp_valid}, 64'd0);
    check("rst.mem_wren", {63'b0, mem_wren}, 64'd0);
    check("rst.mem_rden", {63'b0, mem_rden}, 64'd0);
    check("rst.mem_addr", mem_addr, 64'd0);
    check("rst.mem_d", mem_d, 64'd0);
    check("rst.resp_rdata", resp_rdata, 64'd0);
    check("rst.resp_err", {63'b0, resp_err}, 64'd0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check("rst.ready", {63'b0, req_ready}, 64'd1);

    // Loads (funct3 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 110 LWU)
    xact("LB9",  0, 3'b000, 64'h9, 0, 2, 64'hFFFF_FFFF_FFFF_FFCD, 0, 1, 0, 64'd1, 0);
    xact("LBU9", 0, 3'b100, 64'h9, 0, 2, 64'h0000_0000_0000_00CD, 0, 1, 0, 64'd1, 0);
    xact("LWC",  0, 3'b010, 64'hC, 0, 2, 64'h0000_0000_0123_4567, 0, 1, 0, 64'd1, 0);
    xact("LWU8", 0, 3'b110, 64'h8, 0, 2, 64'h0000_0000_89AB_CDEF, 0, 1, 0, 64'd1, 0);
    xact("LW8",  0, 3'b010, 64'h8, 0, 2, 64'hFFFF_FFFF_89AB_CDEF, 0, 1, 0, 64'd1, 0);
    xact("LHE",  0, 3'b001, 64'hE, 0, 2, 64'h0000_0000_0000_0123, 0, 1, 0, 64'd1, 0);

    // Sub-word store (read-modify-write), then read back
    xact("SHA", 1, 3'b001, 64'hA, 64'h1234_5678_9ABC_BEEF, 3, 64'h0, 0, 1, 1,
         64'd1, 64'h0123_4567_BEEF_CDEF);
    xact("LD8", 0, 3'b011, 64'h8, 0, 2, 64'h0123_4567_BEEF_CDEF, 0, 1, 0, 64'd1, 0);

    // Full-word store skips the read
    xact("SD10", 1, 3'b011, 64'h10, 64'hDEAD_BEEF_0000_0001, 2, 64'h0, 0, 0, 1,
         64'd2, 64'hDEAD_BEEF_0000_0001);
    xact("LD10", 0, 3'b011, 64'h10, 0, 2, 64'hDEAD_BEEF_0000_0001, 0, 1, 0, 64'd2, 0);

    // Errors: misaligned and illegal
    xact("LWA_mis", 0, 3'b010, 64'hA, 0, 1, 64'h0, 1, 0, 0, 0, 0);
    xact("LD4_mis", 0, 3'b011, 64'h4, 0, 1, 64'h0, 1, 0, 0, 0, 0);
    xact("L111",    0, 3'b111, 64'h8, 0, 1, 64'h0, 1, 0, 0, 0, 0);
    xact("S100",    1, 3'b100, 64'h8, 64'h55, 1, 64'h0, 1, 0, 0, 0, 0);
    // Error flag must clear on the next good response
    xact("LBU9b", 0, 3'b100, 64'h9, 0, 2, 64'h0000_0000_0000_00CD, 0, 1, 0, 64'd1, 0);

    // Reset during WRITE of an SB
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 64'h18; req_wdata = 64'hAA;
    @(posedge clk);
    @(negedge clk); req_valid = 1'b0;            // READ cycle
    @(negedge clk);                               // WRITE cycle
    check("rstw.in_write", {63'b0, mem_wren}, 64'd1);
    #1 rst = 1'b0;
    #1;
    check("rstw.wren_drop", {63'b0, mem_wren}, 64'd0);
    check("rstw.no_resp", {63'b0, resp_valid}, 64'd0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check("rstw.ready", {63'b0, req_ready}, 64'd1);
    check("rstw.mem3_kept", mem[3], 64'h3333_0000_0000_0000);
    ng = 0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) ng++;
    end
    check("rstw.no_late_resp", 64'(ng), 64'd0);

    // Back-to-back with req_valid held high across both requests
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b011; req_addr = 64'h8; req_wdata = 0;
    @(posedge clk);
    @(negedge clk);
    req_funct3 = 3'b100; req_addr = 64'h9;
    ng = 0;
    got[0] = '0; got[1] = '0;
    for (int c = 0; c < 20; c++) begin
      if (resp_valid) begin
        if (ng < 2) got[ng] = resp_rdata;
        ng++;
      end
      if (req_ready && req_valid) begin
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    check("b2b.count", 64'(ng), 64'd2);
    check("b2b.first", got[0], 64'h0123_4567_BEEF_CDEF);
    check("b2b.second", got[1], 64'h0000_0000_0000_00CD);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the core's data-memory interface: accepts RISC-V load/store requests (byte/half/word/double, signed/unsigned) from the execute stage and drives the word-addressed data memory (wren/rden/addr/d/q).
- Handles byte-lane extraction, sign/zero extension, sub-word read-modify-write and misalignment detection.
- Returns one result per request over a valid/ready request handshake and a single-cycle response pulse.

Parameters:
- ADDRSIZE, 64, width of byte address and of mem_addr.
- WORDSIZE, 64, memory word width; only 64 is supported (8 byte lanes).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 size/sign code.
- req_addr  in  ADDRSIZE  byte address.
- req_wdata  in  WORDSIZE  store data; low bytes used for sub-word stores.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  WORDSIZE  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned or illegal request, qualified by resp_valid.
- mem_wren  out  1  memory write enable.
- mem_rden  out  1  memory read enable.
- mem_addr  out  ADDRSIZE  word index = {3'b0, addr[ADDRSIZE-1:3]}.
- mem_d  out  WORDSIZE  write data.
- mem_q  in  WORDSIZE  read data, combinational from memory while mem_rden=1.

Behaviour:
- Reset (rst low, async): state IDLE; resp_valid, resp_err, mem_wren, mem_rden = 0; mem_addr, mem_d, resp_rdata = 0; request latches cleared. req_ready=1 after release.
- A reset asserted mid-operation aborts immediately. A write in progress is dropped (mem_wren falls asynchronously) and no response is issued.
- mem_* and resp_* are decoded from registered state and registers only. There is no combinational path from req_* to any output.
- Accept: req_valid && req_ready at a rising edge latches we, funct3, addr, wdata. req_ready = (state==IDLE).
- Decode, loads: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU, 111 illegal.
- Decode, stores: 000 SB, 001 SH, 010 SW, 011 SD, 1xx illegal.
- Misaligned: H with off[0]≠0; W with off[1:0]≠0; D with off≠0 (off = addr[2:0]).
- FSM states: IDLE, READ, WRITE, RESP.
  - IDLE → RESP (err=1) if illegal or misaligned; no memory access is issued.
  - IDLE → WRITE for SD.
  - IDLE → READ for all loads and for SB/SH/SW (read-modify-write).
  - READ: mem_rden=1, mem_addr=word index. mem_q is captured into rbuf at the end of the cycle.
    - Load: resp_rdata ← extracted value; → RESP.
    - Store: mem_d ← merge(rbuf, wdata); → WRITE.
  - WRITE: mem_wren=1, mem_rden=0, mem_addr=word index, mem_d stable for the whole cycle; → RESP.
  - RESP: resp_valid=1 for exactly one cycle; → IDLE. resp_rdata and resp_err hold until the next RESP.
- mem_wren and mem_rden are never both 1. Both are 0 in IDLE and RESP.
- Latency from the acceptance edge to the resp_valid cycle:
  - Error: 1 cycle.
  - Load or SD: 2 cycles.
  - SB/SH/SW: 3 cycles.
- Throughput: next request is accepted in the IDLE cycle after RESP, one request outstanding at most.
- Extraction: little-endian; lane base = off*8. B/H/W are sign-extended (signed loads) or zero-extended (unsigned loads) to 64 bits; LD passes the word through.
- Merge: only the addressed byte lanes of rbuf are replaced by the low 1/2/4 bytes of wdata; all other lanes keep their read value.
- req_* changes while the unit is busy are ignored.

Test Plan:
- Memory word 1 = 0x0123_4567_89AB_CDEF. LB at 0x9 → mem_rden one cycle with mem_addr=1; resp_valid 2 cycles after accept; resp_rdata=0xFFFF_FFFF_FFFF_FFCD, err=0. LBU at 0x9 → 0x0000_0000_0000_00CD.
- Same word, LW at 0xC → 0x0000_0000_0123_4567. LWU at 0x8 → 0x0000_0000_89AB_CDEF. LW at 0x8 → 0xFFFF_FFFF_89AB_CDEF.
- SH wdata=0x...BEEF at 0xA → mem_rden cycle, then mem_wren cycle with mem_addr=1 and mem_d=0x0123_4567_BEEF_CDEF; resp_valid 3 cycles after accept; a following LD at 0x8 returns the same value.
- SD 0xDEAD_BEEF_0000_0001 at 0x10 → no mem_rden, one mem_wren cycle with mem_addr=2; resp 2 cycles after accept.
- LW at 0xA, LD at 0x4, load funct3=111, store funct3=100 → resp_err=1 one cycle after accept, resp_rdata=0, mem_wren and mem_rden stay 0 throughout.
- Reset pulse during the WRITE cycle of an SB → mem_wren drops immediately, no resp_valid, req_ready=1 after release. Back-to-back requests with req_valid held high → each accepted exactly once, in order.
